// File: rtl/word_to_bit_serializer.sv
// Word-to-bit serializer: captures a WIDTH-bit word on a valid/ready handshake and emits it MSB first.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after the data bits.
module word_to_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             load;
`ifdef SERIALIZER_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (load) begin
        sreg <= in_data;
        cnt  <= CW'(WIDTH - 1);
`ifdef SERIALIZER_PARITY_EN
        par  <= ^in_data;
`endif
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

  // A word may be loaded from IDLE or from the final-bit cycle, giving zero-bubble streaming.
  always_comb begin
    nxt       = state;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_bit   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          nxt  = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = sreg[WIDTH-1];
        if (cnt == '0) begin
`ifdef SERIALIZER_PARITY_EN
          nxt = PARITY;
`else
          out_last = 1'b1;
          in_ready = 1'b1;
          if (in_valid) load = 1'b1;
          else          nxt  = IDLE;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        out_bit   = par;
        out_last  = 1'b1;
        in_ready  = 1'b1;
        if (in_valid) nxt = SHIFT;
        else          nxt = IDLE;
        load = in_valid;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign busy = out_valid;

endmodule

// File: tb/tb_word_to_bit_serializer.sv
// Directed self-checking bench for word_to_bit_serializer (WIDTH=8); follows SERIALIZER_PARITY_EN if defined.
module tb_word_to_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  int total = 0;
  int bad   = 0;

  word_to_bit_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected serial bit i of a word: data MSB first, then even parity.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    if (i < 8) return w[7-i];
    return ^w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    total++;
    if ({out_bit, out_valid, out_last, busy, in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_outputs got bit/valid/last/busy/ready=%b exp=00001",
               {out_bit, out_valid, out_last, busy, in_ready});
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hB3;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready_idle got=%b exp=1", in_ready);
    end
    cyc();
    in_valid = 1'b0; in_data = 8'h00;  // later changes must not affect the word in flight
    for (int i = 0; i < NB; i++) begin
      logic lst;
      lst = (i == NB - 1);
      total++;
      if ({out_valid, out_bit, out_last, in_ready, busy} !== {1'b1, exp_bit(8'hB3, i), lst, lst, 1'b1}) begin
        bad++;
        $display("FAIL single_bit%0d got valid/bit/last/ready/busy=%b exp=%b", i,
                 {out_valid, out_bit, out_last, in_ready, busy}, {1'b1, exp_bit(8'hB3, i), lst, lst, 1'b1});
      end
      cyc();
    end
    total++;
    if ({out_valid, out_bit, out_last, busy, in_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL single_idle_after got=%b exp=00001", {out_valid, out_bit, out_last, busy, in_ready});
    end
  endtask

  // Two words; the second is presented with in_valid high starting at cycle 'offer' of the first.
  task automatic run_pair(input string name, input logic [7:0] w0, input logic [7:0] w1, input int offer);
    in_valid = 1'b1; in_data = w0;
    cyc();
    in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 2 * NB; i++) begin
      logic lst, eb;
      if (i == offer) begin in_valid = 1'b1; in_data = w1; end
      lst = ((i % NB) == NB - 1);
      eb  = (i < NB) ? exp_bit(w0, i) : exp_bit(w1, i - NB);
      total++;
      if ({out_valid, out_bit, out_last, in_ready} !== {1'b1, eb, lst, lst}) begin
        bad++;
        $display("FAIL %s_cycle%0d got valid/bit/last/ready=%b exp=%b", name, i,
                 {out_valid, out_bit, out_last, in_ready}, {1'b1, eb, lst, lst});
      end
      cyc();
      if (i == NB - 1) begin in_valid = 1'b0; in_data = 8'h00; end
    end
    total++;
    if ({out_valid, out_bit, in_ready} !== 3'b001) begin
      bad++; $display("FAIL %s_idle_after got=%b exp=001", name, {out_valid, out_bit, in_ready});
    end
  endtask

  task automatic test_back_to_back();
    run_pair("b2b", 8'hFF, 8'h00, 0);
  endtask

  task automatic test_backpressure();
    run_pair("bp", 8'hB3, 8'h5A, 2);
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_data = 8'hB3;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_bit} !== {1'b1, exp_bit(8'hB3, i)}) begin
        bad++; $display("FAIL rstmid_bit%0d got=%b exp=%b", i, {out_valid, out_bit}, {1'b1, exp_bit(8'hB3, i)});
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({out_valid, out_last, in_ready} !== 3'b001) begin
      bad++; $display("FAIL rstmid_after got valid/last/ready=%b exp=001", {out_valid, out_last, in_ready});
    end
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;  // transfer coinciding with reset is discarded
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_bit} !== 2'b00) begin
        bad++; $display("FAIL rstmid_quiet%0d got valid/bit=%b exp=00", i, {out_valid, out_bit});
      end
      cyc();
    end
  endtask

  task automatic test_idle_gap();
    logic [7:0] words [2];
    words[0] = 8'h03; words[1] = 8'hC5;
    for (int w = 0; w < 2; w++) begin
      in_valid = 1'b1; in_data = words[w];
      cyc();
      in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
        total++;
        if ({out_valid, out_bit, out_last} !== {1'b1, exp_bit(words[w], i), i == NB - 1}) begin
          bad++;
          $display("FAIL gap_w%0d_bit%0d got valid/bit/last=%b exp=%b", w, i,
                   {out_valid, out_bit, out_last}, {1'b1, exp_bit(words[w], i), i == NB - 1});
        end
        cyc();
      end
      for (int g = 0; g < 5; g++) begin
        total++;
        if ({out_valid, out_bit, busy} !== 3'b000) begin
          bad++; $display("FAIL gap_w%0d_idle%0d got valid/bit/busy=%b exp=000", w, g, {out_valid, out_bit, busy});
        end
        cyc();
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
